// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: mode encoding and the
// byte-to-word address helper used on the MEM side.
package mem_arbiter_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    function automatic logic [31:0] mem_word_addr(input logic [31:0] byte_addr);
        return {2'b00, byte_addr[31:2]};
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port word-memory arbiter: loader owns MEM in BOOT, fetch/data share it
// in RUN with data priority and a fetch anti-starvation override.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    input  logic        l_req,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,

    output logic [31:0] m_addr,
    output logic [31:0] m_in,
    output logic        m_we,
    input  logic [31:0] m_out
);

    arb_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_i_rvalid;
    logic             r_d_rvalid;

    arb_state_e       w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_fetch_first;
    logic             w_i_gnt;
    logic             w_d_gnt;
    logic             w_l_gnt;
    logic [31:0]      w_m_addr;
    logic [31:0]      w_m_in;
    logic             w_m_we;

    assign w_fetch_first = (r_cnt >= CNT_W'(STARVE_MAX));

    always_comb begin
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
        w_l_gnt = 1'b0;
        if (!rst) begin
            if (r_state == ST_BOOT) begin
                w_l_gnt = l_req;
            end else if (i_req && (w_fetch_first || !d_req)) begin
                w_i_gnt = 1'b1;
            end else if (d_req) begin
                w_d_gnt = 1'b1;
            end
        end
    end

    // Idle cycles present the fetch address as a harmless read.
    always_comb begin
        w_m_addr = mem_word_addr(i_addr);
        w_m_in   = d_wdata;
        w_m_we   = 1'b0;
        if (w_l_gnt) begin
            w_m_addr = mem_word_addr(l_addr);
            w_m_in   = l_wdata;
            w_m_we   = 1'b1;
        end else if (w_d_gnt) begin
            w_m_addr = mem_word_addr(d_addr);
            w_m_we   = d_we;
        end
    end

    always_comb begin
        w_state_next = boot ? ST_BOOT : ST_RUN;
        w_cnt_next   = '0;
        if (r_state == ST_RUN && i_req && !w_i_gnt) begin
            w_cnt_next = w_fetch_first ? r_cnt : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_cnt      <= '0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_i_rvalid <= w_i_gnt;
            r_d_rvalid <= w_d_gnt & ~d_we;
        end
    end

    assign i_gnt    = w_i_gnt;
    assign d_gnt    = w_d_gnt;
    assign l_gnt    = w_l_gnt;
    assign i_rvalid = r_i_rvalid;
    assign d_rvalid = r_d_rvalid;
    assign i_rdata  = m_out;
    assign d_rdata  = m_out;
    assign m_addr   = w_m_addr;
    assign m_in     = w_m_in;
    assign m_we     = w_m_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural MEM and a
// rule-level reference model of modes, priority and fetch starvation.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst, boot;
    logic        i_req, d_req, d_we, l_req;
    logic [31:0] i_addr, d_addr, d_wdata, l_addr, l_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, l_gnt, m_we;
    logic [31:0] i_rdata, d_rdata, m_addr, m_in, m_out;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .boot(boot),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
        .m_addr(m_addr), .m_in(m_in), .m_we(m_we), .m_out(m_out)
    );

    always #5 clk = ~clk;

    // Behavioural MEM: 64 words, one-cycle read latency.
    logic [31:0] mem_arr [64];
    always @(posedge clk) begin
        if (m_we) mem_arr[m_addr[5:0]] <= m_in;
        m_out <= mem_arr[m_addr[5:0]];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model state.
    logic [31:0] ref_mem [64];
    bit          mode_run = 1'b0;
    int          starve   = 0;
    logic [31:0] exp_i_q [$];
    logic [31:0] exp_d_q [$];

    always @(negedge clk) begin
        bit eg_i, eg_d, eg_l, ew;
        logic [31:0] ea;
        eg_i = 0; eg_d = 0; eg_l = 0;
        if (rst) begin
            chk("rst_i_gnt", {31'b0, i_gnt}, 32'd0);
            chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
            chk("rst_l_gnt", {31'b0, l_gnt}, 32'd0);
            chk("rst_m_we", {31'b0, m_we}, 32'd0);
            mode_run = 1'b0;
            starve   = 0;
            exp_i_q.delete();
            exp_d_q.delete();
        end else begin
            if (!mode_run) eg_l = l_req;
            else if (i_req && (starve == STARVE_MAX || !d_req)) eg_i = 1;
            else if (d_req) eg_d = 1;

            ew = eg_l || (eg_d && d_we);
            ea = eg_l ? {2'b0, l_addr[31:2]} : eg_d ? {2'b0, d_addr[31:2]} : {2'b0, i_addr[31:2]};
            chk("i_gnt", {31'b0, i_gnt}, {31'b0, eg_i});
            chk("d_gnt", {31'b0, d_gnt}, {31'b0, eg_d});
            chk("l_gnt", {31'b0, l_gnt}, {31'b0, eg_l});
            chk("m_we", {31'b0, m_we}, {31'b0, ew});
            chk("m_addr", m_addr, ea);
            if (ew) chk("m_in", m_in, eg_l ? l_wdata : d_wdata);

            if (eg_l) ref_mem[l_addr[7:2]] = l_wdata;
            if (eg_d && d_we) ref_mem[d_addr[7:2]] = d_wdata;
            if (eg_d && !d_we) exp_d_q.push_back(ref_mem[d_addr[7:2]]);
            if (eg_i) exp_i_q.push_back(ref_mem[i_addr[7:2]]);

            if (mode_run && i_req && !eg_i) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
            else starve = 0;
            mode_run = !boot;
        end
    end

    // Monitor: read responses must appear exactly when the model expects one.
    always @(posedge clk) begin
        #2;
        if (exp_i_q.size() != 0) begin
            chk("i_rvalid", {31'b0, i_rvalid}, 32'd1);
            chk("i_rdata", i_rdata, exp_i_q.pop_front());
        end else begin
            chk("i_rvalid_idle", {31'b0, i_rvalid}, 32'd0);
        end
        if (exp_d_q.size() != 0) begin
            chk("d_rvalid", {31'b0, d_rvalid}, 32'd1);
            chk("d_rdata", d_rdata, exp_d_q.pop_front());
        end else begin
            chk("d_rvalid_idle", {31'b0, d_rvalid}, 32'd0);
        end
    end

    bit ig, dg, lg;

    task automatic step();
        @(negedge clk);
        ig = i_gnt; dg = d_gnt; lg = l_gnt;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        return {24'b0, 8'($urandom)};
    endfunction

    initial begin
        for (int k = 0; k < 64; k++) begin
            mem_arr[k] = '0;
            ref_mem[k] = '0;
        end
        rst = 1; boot = 1;
        i_req = 0; d_req = 0; d_we = 0; l_req = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; l_addr = 0; l_wdata = 0;
        step(); step();

        // Loader write while fetch/data also request.
        rst = 0; l_req = 1; l_addr = 32'h10; l_wdata = 32'hDEADBEEF;
        i_req = 1; i_addr = 32'h10; d_req = 1; d_addr = 32'h10;
        step();
        l_req = 0; boot = 0; d_req = 0;
        step();  // last BOOT cycle
        step();  // fetch of the loaded word
        i_req = 0;
        step();

        // Contention: data wins until fetch has starved STARVE_MAX cycles.
        i_req = 1; d_req = 1; d_we = 0; d_addr = 32'h12;
        repeat (12) step();

        // Store then load of the same word.
        i_req = 0; d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678;
        step();
        d_we = 0; d_addr = 32'h23;
        step();
        d_req = 0;
        step(); step();

        // Load granted in the cycle boot rises.
        d_req = 1; d_we = 0; d_addr = 32'h20; boot = 1;
        step();
        i_req = 1;
        step(); step();
        i_req = 0; d_req = 0; boot = 0;
        step();

        // Reset while fetch has starved three cycles.
        i_req = 1; d_req = 1;
        repeat (3) step();
        rst = 1;
        step();
        rst = 0;
        repeat (8) step();
        i_req = 0; d_req = 0;
        step();

        // Randomized traffic obeying hold-until-grant.
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) boot = ~boot;
            if (!i_req || ig) begin
                i_req = ($urandom_range(0, 2) != 0);
                i_addr = rand_addr();
            end
            if (!d_req || dg) begin
                d_req = ($urandom_range(0, 2) != 0);
                d_we = $urandom_range(0, 1);
                d_addr = rand_addr();
                d_wdata = $urandom;
            end
            if (!l_req || lg) begin
                l_req = ($urandom_range(0, 1) != 0);
                l_addr = rand_addr();
                l_wdata = $urandom;
            end
            step();
        end

        rst = 0; i_req = 0; d_req = 0; l_req = 0;
        step(); step(); step();
        chk("i_q_drained", exp_i_q.size(), 32'd0);
        chk("d_q_drained", exp_d_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
